seq_detector: RTL

Parametrised Mealy sequence detector: the general successor of the team's fixed 3-state Mealy FSMs. It matches an arbitrary compile-time pattern of LEN symbols, each W bits wide, on a qualified input stream. A mode parameter selects overlapping or non-overlapping matching. It flags each match combinationally in the cycle of the final symbol and keeps a saturating count of matches. It sits on any serial/symbol stream where the design needs pattern recognition.

---
 rtl/seq_det_pkg.sv | 73 +++++++
 rtl/seq_detector_sat_counter.sv | 44 ++++
 rtl/seq_detector.sv | 113 +++++++++++
 3 files changed

// File: rtl/seq_det_pkg.sv
// ---------------------------------------------------------------------------
// seq_det_pkg
//
// Shared elaboration-time helpers for the parametrised sequence detector.
//   patSym      - extracts symbol idx of a packed pattern (symbol 0 in the MS bits)
//   next_state  - KMP-style transition: the longest pattern prefix that is a
//                 suffix of (matched prefix of length k, followed by sym),
//                 capped at len-1 so a full match falls back to fail[len]
//   satIncr     - saturating increment used by the match counter
//
// All functions are evaluated only at elaboration to build constant tables.
// Patterns up to MAX_PAT_BITS bits and symbols up to MAX_W bits are supported.
// ---------------------------------------------------------------------------
package seq_det_pkg;

  localparam int MAX_PAT_BITS = 256;
  localparam int MAX_W        = 32;

  // Returns pattern symbol idx, zero-extended to MAX_W bits.
  function automatic logic [MAX_W-1:0] patSym(input logic [MAX_PAT_BITS-1:0] pattern,
                                              input int w,
                                              input int len,
                                              input int idx);
    logic [MAX_PAT_BITS-1:0] shifted;
    logic [MAX_W-1:0]        mask;
    shifted = pattern >> ((len - 1 - idx) * w);
    if (w >= MAX_W) begin
      mask = '1;
    end else begin
      mask = MAX_W'((64'd1 << w) - 64'd1);
    end
    return shifted[MAX_W-1:0] & mask;
  endfunction

  // Brute-force border search. The examined string is the first k pattern
  // symbols followed by sym (length k+1). The candidate prefix length is
  // capped at len-1: for a completed match this yields the proper border,
  // i.e. the failure value fail[len] used for overlapping restarts.
  function automatic int next_state(input logic [MAX_PAT_BITS-1:0] pattern,
                                    input int w,
                                    input int len,
                                    input int k,
                                    input logic [MAX_W-1:0] sym);
    int               maxLen;
    int               best;
    int               j;
    bit               ok;
    logic [MAX_W-1:0] strSym;
    maxLen = (k + 1 < len - 1) ? (k + 1) : (len - 1);
    best   = 0;
    for (int l = 1; l <= maxLen; l++) begin
      ok = 1'b1;
      for (int i = 0; i < l; i++) begin
        j = k + 1 - l + i;
        strSym = (j == k) ? sym : patSym(pattern, w, len, j);
        if (patSym(pattern, w, len, i) != strSym) begin
          ok = 1'b0;
        end
      end
      if (ok) begin
        best = l;
      end
    end
    return best;
  endfunction

  // Increment that sticks at maxValue instead of wrapping.
  function automatic logic [63:0] satIncr(input logic [63:0] value,
                                          input logic [63:0] maxValue);
    return (value >= maxValue) ? value : (value + 64'd1);
  endfunction

endpackage

// File: rtl/seq_detector_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
//
// Saturating event counter owning the detector's match_count.
//   clk    in   rising-edge clock
//   reset  in   synchronous active-high reset (highest priority)
//   clear  in   synchronous clear (beats a same-cycle increment)
//   inc    in   count one event this cycle
//   count  out  CNT_W-bit count, sticks at all-ones
// ---------------------------------------------------------------------------
module sat_counter
  import seq_det_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [63:0] MAX_COUNT = 64'((65'd1 << CNT_W) - 65'd1);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_countInc;

  assign w_countInc = CNT_W'(satIncr(64'(r_count), MAX_COUNT));

  // Count register: reset first, then clear, then the saturating increment,
  // so a clear coinciding with a match leaves the count at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (inc) begin
      r_count <= w_countInc;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/seq_detector.sv
// ---------------------------------------------------------------------------
// seq_detector
//
// Parametrised Mealy sequence detector for a compile-time pattern of LEN
// symbols of W bits each (symbol 0 in the MS bits of PATTERN). The state is
// the length of the currently matched prefix; transitions come from a
// constant KMP table built at elaboration. OVERLAP selects whether a match
// restarts from the pattern's longest proper border or from scratch.
//   clk          in   rising-edge clock
//   reset        in   synchronous active-high reset
//   x_valid      in   qualifies X this cycle
//   X            in   W-bit input symbol
//   clear        in   synchronous clear of match_count only
//   Y            out  combinational match flag, same cycle as final symbol
//   state_o      out  matched-prefix length, 0..LEN-1
//   match_count  out  CNT_W-bit saturating match count
// ---------------------------------------------------------------------------
module seq_detector
  import seq_det_pkg::*;
#(
  parameter int               W       = 1,
  parameter int               LEN     = 4,
  parameter logic [LEN*W-1:0] PATTERN = 4'b1011,
  parameter int               OVERLAP = 1,
  parameter int               CNT_W   = 8
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  x_valid,
  input  logic [W-1:0]                          X,
  input  logic                                  clear,
  output logic                                  Y,
  output logic [((LEN > 1) ? $clog2(LEN) : 1)-1:0] state_o,
  output logic [CNT_W-1:0]                      match_count
);

  localparam int SW      = (LEN > 1) ? $clog2(LEN) : 1;
  localparam int NSTATES = 2 ** SW;
  localparam int NSYMS   = 2 ** W;

  localparam logic [MAX_PAT_BITS-1:0] PAT_EXT  = MAX_PAT_BITS'(PATTERN);
  localparam logic [W-1:0]            LAST_SYM = PATTERN[W-1:0];
  localparam logic [SW-1:0]           LAST_ST  = SW'(LEN - 1);
  localparam int FAIL_LEN = next_state(PAT_EXT, W, LEN, LEN - 1,
                                       patSym(PAT_EXT, W, LEN, LEN - 1));

  logic [SW-1:0] r_state;
  logic [SW-1:0] w_nextState;
  logic          w_match;
  logic          w_illegal;
  logic [SW-1:0] w_nextTbl [NSTATES][NSYMS];

  // Constant transition table. Rows beyond LEN-1 only exist when LEN is not
  // a power of two; they are never consulted because w_illegal takes over.
  for (genvar k = 0; k < NSTATES; k++) begin : g_row
    for (genvar s = 0; s < NSYMS; s++) begin : g_col
      if (k < LEN) begin : g_legal
        localparam int NS = next_state(PAT_EXT, W, LEN, k, MAX_W'(s));
        assign w_nextTbl[k][s] = SW'(NS);
      end else begin : g_unused
        assign w_nextTbl[k][s] = '0;
      end
    end
  end

  // Out-of-range state detection only makes sense when the state register
  // can hold values above LEN-1.
  if (LEN < NSTATES) begin : g_illegalChk
    assign w_illegal = (r_state > LAST_ST);
  end else begin : g_noIllegal
    assign w_illegal = 1'b0;
  end

  // Next-state and Mealy output. Y is forced low during reset so a matching
  // symbol presented with reset neither flags nor counts.
  always_comb begin
    w_nextState = r_state;
    w_match     = 1'b0;
    if (!reset && x_valid) begin
      if (w_illegal) begin
        w_nextState = '0;
      end else if ((r_state == LAST_ST) && (X == LAST_SYM)) begin
        w_match     = 1'b1;
        w_nextState = (OVERLAP != 0) ? SW'(FAIL_LEN) : '0;
      end else begin
        w_nextState = w_nextTbl[r_state][X];
      end
    end
  end

  // Matched-prefix register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= '0;
    end else begin
      r_state <= w_nextState;
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_matchCounter (
    .clk  (clk),
    .reset(reset),
    .clear(clear),
    .inc  (w_match),
    .count(match_count)
  );

  assign Y       = w_match;
  assign state_o = r_state;

endmodule
